// File: rtl/ifetch_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ifetch_ctrl_pkg
// Shared types and constants for the instruction-fetch sequencer:
//   - default reset PC and exception vector
//   - EXC_ADEL exception code for a misaligned fetch address
//   - fetch packet layout (pc, instruction pair, slot mask, exception info)
//   - FSM state and redirect-source encodings
// ----------------------------------------------------------------------------
package ifetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'hbfc0_0000;
  localparam logic [31:0] EX_VEC_DEF   = 32'hbfc0_0380;
  localparam logic [4:0]  EXC_ADEL     = 5'h04;

  // Width of one packet handed to the instruction FIFO.
  localparam int FS_BUS_WD = 32 + 64 + 2 + 1 + 5;

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] inst;
    logic [1:0]  mask;
    logic        ex;
    logic [4:0]  excode;
  } fs_pkt_t;

  typedef logic [FS_BUS_WD-1:0] fs_bus_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Ordered so that a larger value is a higher-priority redirect.
  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_BR   = 2'd1,
    RD_ERET = 2'd2,
    RD_EX   = 2'd3
  } redir_t;

  // A fetch at an odd word only delivers one instruction, so it advances by 4.
  function automatic logic [31:0] seq_next_pc(input logic [31:0] pc);
    return pc + (pc[2] ? 32'd4 : 32'd8);
  endfunction

endpackage

// File: rtl/ifetch_ctrl_if.sv
// ----------------------------------------------------------------------------
// ifetch_ctrl_if
// SRAM-like instruction bus between the fetch sequencer (master) and the
// instruction memory / cache (slave).
//   inst_sram_req/addr/size : request, held by the master until addr_ok
//   inst_uncache            : address lies in the uncached kseg1 window
//   inst_sram_addr_ok       : request accepted
//   inst_sram_data_ok/rdata : in-order response, 64-bit instruction pair
// ----------------------------------------------------------------------------
interface ifetch_ctrl_if;

  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic [1:0]  inst_sram_size;
  logic        inst_uncache;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [63:0] inst_sram_rdata;

  modport master (
    output inst_sram_req, inst_sram_addr, inst_sram_size, inst_uncache,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
  );

  modport slave (
    input  inst_sram_req, inst_sram_addr, inst_sram_size, inst_uncache,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
  );

endinterface

// File: rtl/ifetch_ctrl_pc_queue.sv
// ----------------------------------------------------------------------------
// ifetch_ctrl_pc_queue
// In-order FIFO of the PCs of accepted-but-unanswered fetch requests.
//   push/push_pc : record the PC of a request on its handshake
//   pop/pop_pc   : head PC, consumed when the matching response returns
//   count        : number of entries (the outstanding-request count)
// There is no flush: stale entries drain through the normal pop path.
// The parent never pushes when full or pops when empty.
// ----------------------------------------------------------------------------
module ifetch_ctrl_pc_queue #(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           push,
  input  logic [31:0]                    push_pc,
  input  logic                           pop,
  output logic [31:0]                    pop_pc,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: storage has no reset; an entry is only read after it was written,
  // and leaving it out of reset lets it map onto plain flops or LUT RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_pc;
  end

  assign pop_pc = mem[rd_ptr];

endmodule

// File: rtl/ifetch_ctrl.sv
// ----------------------------------------------------------------------------
// ifetch_ctrl
// Fetch sequencer for the dual-issue front end.
//   clk, resetn         : clock, asynchronous active-low reset
//   ex_taken/eret_taken/br_prd_err, epc, br_target : redirect pulses, targets
//   fifo_allowin        : instruction FIFO can take a packet next cycle
//   sram (master)       : SRAM-like instruction bus
//   fs_valid, fs_pc, fs_inst, fs_mask, fs_ex, fs_excode : registered packet
// Redirect priority is exception > eret > mispredict > sequential. A request
// presented without addr_ok is held unchanged; redirects arriving meanwhile
// are parked in a pending register and applied on the handshake. Responses to
// requests accepted at or before a redirect are counted in drop_cnt and
// discarded. A misaligned PC issues no request; once the bus is idle it emits
// one ADEL packet and parks in HOLD until the next redirect.
// MAX_OUT must be 1..3.
// ----------------------------------------------------------------------------
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] EX_VEC   = EX_VEC_DEF,
  parameter int          MAX_OUT  = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ex_taken,
  input  logic                eret_taken,
  input  logic [31:0]         epc,
  input  logic                br_prd_err,
  input  logic [31:0]         br_target,
  input  logic                fifo_allowin,
  ifetch_ctrl_if.master       sram,
  output logic                fs_valid,
  output logic [31:0]         fs_pc,
  output logic [63:0]         fs_inst,
  output logic [1:0]          fs_mask,
  output logic                fs_ex,
  output logic [4:0]          fs_excode
);

  localparam int CW = $clog2(MAX_OUT + 1);

  state_t        state;
  logic [31:0]   pc;
  logic          alive;       // first cycle out of reset issues nothing
  logic          held;        // request shown last cycle, not yet accepted
  logic          pend_valid;
  redir_t        pend_src;
  logic [31:0]   pend_pc;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] drop_cnt;
  logic [31:0]   head_pc;
  fs_pkt_t       fs_q;

  redir_t        new_src;
  logic [31:0]   new_pc;
  logic          redir;
  logic          new_wins;
  logic          tgt_valid;
  logic [31:0]   tgt_pc;
  logic          misaligned;
  logic          issue_ok;
  logic          req;
  logic          hs;
  logic          rsp_valid;
  logic          drop_now;

  // NOTE: every signal written here gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    new_src = RD_NONE;
    new_pc  = '0;
    if (ex_taken) begin
      new_src = RD_EX;
      new_pc  = EX_VEC;
    end else if (eret_taken) begin
      new_src = RD_ERET;
      new_pc  = epc;
    end else if (br_prd_err) begin
      new_src = RD_BR;
      new_pc  = br_target;
    end
  end

  assign redir      = (new_src != RD_NONE);
  // A parked redirect is only displaced by one of equal or higher priority.
  assign new_wins   = redir && (!pend_valid || (new_src >= pend_src));
  assign tgt_valid  = pend_valid || redir;
  assign tgt_pc     = new_wins ? new_pc : pend_pc;

  assign misaligned = (pc[1:0] != 2'b00);
  assign issue_ok   = alive && (state == ST_RUN) && (out_cnt < CW'(MAX_OUT))
                      && fifo_allowin && !misaligned;
  assign req        = held || issue_ok;
  assign hs         = req && sram.inst_sram_addr_ok;
  assign rsp_valid  = sram.inst_sram_data_ok;
  assign drop_now   = rsp_valid && (drop_cnt != '0);

  assign sram.inst_sram_req  = req;
  assign sram.inst_sram_addr = {pc[31:3], 3'b000};
  assign sram.inst_sram_size = 2'h3;
  assign sram.inst_uncache   = (sram.inst_sram_addr[31:29] == 3'b101);

  ifetch_ctrl_pc_queue #(.DEPTH(MAX_OUT)) u_pc_queue (
    .clk     (clk),
    .resetn  (resetn),
    .push    (hs),
    .push_pc (pc),
    .pop     (rsp_valid),
    .pop_pc  (head_pc),
    .count   (out_cnt)
  );

  // NOTE: state registers use non-blocking assignments so every read in this
  // block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_RUN;
      pc         <= RESET_PC;
      alive      <= 1'b0;
      held       <= 1'b0;
      pend_valid <= 1'b0;
      pend_src   <= RD_NONE;
      pend_pc    <= '0;
      drop_cnt   <= '0;
      fs_valid   <= 1'b0;
      fs_q       <= '0;
    end else begin
      alive    <= 1'b1;
      held     <= req && !sram.inst_sram_addr_ok;
      fs_valid <= 1'b0;

      // Everything accepted up to and including a redirect cycle is stale;
      // a held request that completes under a parked redirect is stale too.
      if (redir) begin
        drop_cnt <= out_cnt - CW'(rsp_valid) + CW'(hs);
      end else begin
        drop_cnt <= drop_cnt - CW'(drop_now) + CW'(hs && pend_valid);
      end

      if (hs) begin
        pc         <= tgt_valid ? tgt_pc : seq_next_pc(pc);
        pend_valid <= 1'b0;
        pend_src   <= RD_NONE;
      end else if (req) begin
        if (new_wins) begin
          pend_valid <= 1'b1;
          pend_src   <= new_src;
          pend_pc    <= new_pc;
        end
      end else if (redir) begin
        pc <= new_pc;
      end

      case (state)
        ST_RUN: begin
          if (!redir && misaligned && (out_cnt == '0)) begin
            state    <= ST_HOLD;
            fs_valid <= 1'b1;
            fs_q     <= '{pc: pc, inst: 64'h0, mask: 2'b10,
                          ex: 1'b1, excode: EXC_ADEL};
          end
        end
        ST_HOLD: begin
          if (redir) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase

      if (rsp_valid && !drop_now) begin
        fs_valid <= 1'b1;
        fs_q     <= '{pc: head_pc, inst: sram.inst_sram_rdata,
                      mask: head_pc[2] ? 2'b10 : 2'b11,
                      ex: 1'b0, excode: 5'h0};
      end
    end
  end

  assign fs_pc     = fs_q.pc;
  assign fs_inst   = fs_q.inst;
  assign fs_mask   = fs_q.mask;
  assign fs_ex     = fs_q.ex;
  assign fs_excode = fs_q.excode;

  a_out_cnt_max : assert property (@(posedge clk) disable iff (!resetn)
    out_cnt <= CW'(MAX_OUT));
  a_drop_le_out : assert property (@(posedge clk) disable iff (!resetn)
    drop_cnt <= out_cnt);
  a_no_orphan_rsp : assert property (@(posedge clk) disable iff (!resetn)
    !(rsp_valid && (out_cnt == '0)));

endmodule
